instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Sequential program loader: the inverse of the control decoder.
- Accepts decoded instruction fields over a valid/ready handshake, assembles the 32-bit machine word in the instruction format the decoder consumes, and writes it into instruction memory at consecutive word addresses.
- Sits between a bench/boot host and the instruction memory write port; it fills imem before the processor is released from reset.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first word written.
- DEPTH, 64, maximum number of words written per load session.
- CNT_W, 7, width of the word counter; must hold the value DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; opens a load session.
- finish  input  1  single-cycle pulse; closes the session early.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_class  input  2  00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
- in_cond  input  4  condition field.
- in_cmd  input  4  ALU command (DP only).
- in_s  input  1  set-flags bit (DP only).
- in_imm  input  1  immediate operand select (DP and memory).
- in_load  input  1  1 = LDR, 0 = STR.
- in_byte  input  1  byte access (memory only).
- in_rn  input  4  first source register.
- in_rd  input  4  destination register.
- in_src2  input  12  Src2 or offset field.
- in_imm24  input  24  branch offset.
- we  output  1  imem write strobe.
- waddr  output  32  imem byte address.
- wdata  output  32  encoded instruction.
- count  output  CNT_W  words written in the current session.
- done  output  1  session closed.
- err  output  1  sticky; an illegal class was received.

Behaviour:
- Reset (asynchronous, any state, including mid-session): state IDLE; we=0, waddr=0, wdata=0, count=0, done=0, err=0. Words already written to imem are not undone.
- States:
  - IDLE: start -> RUN. count and err clear on the transition.
  - RUN: accepts bundles. Goes to DONE on finish, or when count reaches DEPTH.
  - DONE: done=1, holds. start -> RUN, clearing count, err and done.
- in_ready = (state==RUN) and (count<DEPTH). It is combinational from registered state only and never depends on in_valid.
- A bundle is accepted when in_valid & in_ready at a rising edge. in_valid may be held high; one bundle is accepted per cycle.
- Write timing: latency 1 cycle. The cycle after acceptance:
  - we=1 for exactly one cycle.
  - waddr = BASE_ADDR + 4*count_old.
  - wdata = the encoded word.
  - count = count_old + 1.
  - Back-to-back accepts give a continuous we pulse train with consecutive addresses.
- Encoding, MSB to LSB:
  - class 00: cond, 2'b00, imm, cmd, s, rn, rd, src2.
  - class 01: cond, 2'b01, ~imm, 1 (P), 1 (U), byte, 0 (W), load, rn, rd, src2.
  - class 10: cond, 2'b10, 1, 0 (link), imm24.
- Illegal class 11: the bundle is accepted, err sets and stays set, we stays 0, count is unchanged.
- Fields not used by the class are ignored.
- Full: after the write that makes count==DEPTH, state is DONE on that same edge. in_ready=0 from then on, and there is no address wrap.
- Simultaneous finish and accept in RUN: the bundle is written (we next cycle), then the state is DONE.
- start while in RUN: ignored. finish while in IDLE or DONE: ignored.
- waddr and wdata hold their last values when we=0.

Test Plan:
- Reset, start, then bundle {00, E, cmd 0100, s0, imm1, rn0, rd2, src2 005} -> one cycle later we=1, waddr=0, wdata=E2802005, count=1.
- Back-to-back: {01, E, imm1, load1, byte0, rn0, rd1, src2 008}, {00, E, 0010, s1, imm1, rn1, rd1, 001}, {10, E, imm24 000002} -> wdata E5901008, E2511001, EA000002 at waddr 0, 4, 8 on consecutive cycles; count=3.
- DEPTH=4, stream 6 bundles with in_valid held high -> exactly 4 writes at 0x0 to 0xC; in_ready drops after the 4th accept; done=1; no write to 0x10.
- Class 11 bundle mid-stream -> err=1, no we pulse, next legal bundle written at the next address with no gap; a new start clears err.
- finish asserted in the same cycle as an accept -> that word is written, then done=1 and in_ready=0. A following start gives count=0 and the next write lands at BASE_ADDR.
- Assert reset in the cycle a write is pending -> we, count and done are 0 immediately (asynchronous). With start not asserted, the block stays in IDLE and in_ready=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into machine words and streams them into imem.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [3:0]       in_cond,
  input  logic [3:0]       in_cmd,
  input  logic             in_s,
  input  logic             in_imm,
  input  logic             in_load,
  input  logic             in_byte,
  input  logic [3:0]       in_rn,
  input  logic [3:0]       in_rd,
  input  logic [11:0]      in_src2,
  input  logic [23:0]      in_imm24,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  state_t state, state_n;
  logic acc, legal;
  logic [31:0] enc;
  assign acc   = in_valid & in_ready;
  assign legal = in_class != 2'b11;
  always_comb begin
    enc = in_class == 2'b00 ? {in_cond, 2'b00, in_imm, in_cmd, in_s, in_rn, in_rd, in_src2} :
          in_class == 2'b01 ? {in_cond, 2'b01, ~in_imm, 2'b11, in_byte, 1'b0, in_load, in_rn, in_rd, in_src2} :
                              {in_cond, 2'b10, 2'b10, in_imm24};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // the accept that fills the last slot closes the session on the same edge
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? ((finish || (acc && legal && count == LAST_C)) ? FULL : RUN) :
                              (start ? RUN : FULL);
  end
  always_comb begin
    in_ready = state == RUN && count < DEPTH_C;
    done     = state == FULL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      we <= acc && legal;
      if (acc && legal) begin
        waddr <= BASE_ADDR + (32'(count) << 2);
        wdata <= enc;
        count <= count + CNT_W'(1);
      end
      if (acc && !legal) err <= 1'b1;
      if (start && state != RUN) begin
        count <= '0;
        err   <= 1'b0;
      end
    end
  end
endmodule
